mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 150 +++++++++++++++
 tb/tb_mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory pipeline stage. Resolves writeback data (load extension
//             or ALU result) when an entry is accepted, and buffers up to two
//             resolved entries in a circular FIFO towards writeback.
//  Ports    : clk, rst (synchronous, active low)
//             exe_to_mem_valid / mem_to_exe_ready / exe_to_mem_bus  (upstream)
//               bus = {regW, regAddr, aluResult, load_inst[2:0], load_data}
//             mem_to_wb_valid / wb_to_mem_ready / mem_to_wb_bus     (downstream)
//               bus = {regW, regAddr, wdata}
//             mem_byp_valid / mem_byp_addr / mem_byp_data (MEM_STAGE_BYPASS_EN)
//  Options  : MEM_STAGE_BYPASS_EN - adds forwarding outputs for the youngest
//             buffered entry.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   exe_to_mem_valid,
    output logic                                   mem_to_exe_ready,
    input  logic [DATA_WIDTH*2+REG_ADDR_WIDTH+3:0] exe_to_mem_bus,
    output logic                                   mem_to_wb_valid,
    input  logic                                   wb_to_mem_ready,
    output logic [DATA_WIDTH+REG_ADDR_WIDTH:0]     mem_to_wb_bus
`ifdef MEM_STAGE_BYPASS_EN
    ,
    output logic                                   mem_byp_valid,
    output logic [REG_ADDR_WIDTH-1:0]              mem_byp_addr,
    output logic [DATA_WIDTH-1:0]                  mem_byp_data
`endif
);

    localparam int c_IN_W = DATA_WIDTH*2 + REG_ADDR_WIDTH + 4;

    // ------------------------------------------------------------------
    // Input bus fields
    // ------------------------------------------------------------------
    logic                      w_in_regw;
    logic [REG_ADDR_WIDTH-1:0] w_in_addr;
    logic [DATA_WIDTH-1:0]     w_in_alu;
    logic [2:0]                w_in_load;
    logic [DATA_WIDTH-1:0]     w_in_ldata;

    assign w_in_regw  = exe_to_mem_bus[c_IN_W-1];
    assign w_in_addr  = exe_to_mem_bus[c_IN_W-2 -: REG_ADDR_WIDTH];
    assign w_in_alu   = exe_to_mem_bus[2*DATA_WIDTH+2 -: DATA_WIDTH];
    assign w_in_load  = exe_to_mem_bus[DATA_WIDTH+2 -: 3];
    assign w_in_ldata = exe_to_mem_bus[DATA_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Writeback resolution, done before storage so the FIFO holds only
    // final {regW, regAddr, wdata} values.
    // ------------------------------------------------------------------
    logic                  w_res_regw;
    logic [DATA_WIDTH-1:0] w_res_data;

    always_comb begin
        w_res_regw = w_in_regw;
        w_res_data = w_in_alu;
        case (w_in_load)
            3'd0: w_res_data = w_in_alu;
            3'd1: w_res_data = {{(DATA_WIDTH-8){w_in_ldata[7]}},   w_in_ldata[7:0]};
            3'd2: w_res_data = {{(DATA_WIDTH-16){w_in_ldata[15]}}, w_in_ldata[15:0]};
            3'd3: w_res_data = w_in_ldata;
            3'd4: w_res_data = {{(DATA_WIDTH-8){1'b0}},  w_in_ldata[7:0]};
            3'd5: w_res_data = {{(DATA_WIDTH-16){1'b0}}, w_in_ldata[15:0]};
            default: begin
                // Undefined load encodings: the write is suppressed.
                w_res_regw = 1'b0;
                w_res_data = '0;
            end
        endcase
        // x0 is hardwired to zero and is never written.
        if (w_in_addr == '0) begin
            w_res_regw = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Two-entry circular FIFO
    // ------------------------------------------------------------------
    logic [1:0]                r_count;
    logic                      r_head;
    logic                      r_tail;
    logic                      r_regw [0:1];
    logic [REG_ADDR_WIDTH-1:0] r_addr [0:1];
    logic [DATA_WIDTH-1:0]     r_data [0:1];

    logic w_enq;
    logic w_deq;

    // Both handshake qualifiers come from r_count only, so ready never
    // depends combinationally on the downstream ready.
    assign mem_to_exe_ready = (r_count != 2'd2);
    assign mem_to_wb_valid  = (r_count != 2'd0);
    assign w_enq            = exe_to_mem_valid && mem_to_exe_ready;
    assign w_deq            = mem_to_wb_valid  && wb_to_mem_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            // One-bit pointers wrap 1 -> 0 by inversion.
            if (w_enq) begin
                r_tail <= ~r_tail;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; empty gating keeps outputs clean.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_regw[r_tail] <= w_res_regw;
            r_addr[r_tail] <= w_in_addr;
            r_data[r_tail] <= w_res_data;
        end
    end

    assign mem_to_wb_bus = mem_to_wb_valid
                         ? {r_regw[r_head], r_addr[r_head], r_data[r_head]}
                         : '0;

`ifdef MEM_STAGE_BYPASS_EN
    // ------------------------------------------------------------------
    // Forwarding of the youngest buffered entry (slot tail-1).
    // ------------------------------------------------------------------
    logic w_young;

    assign w_young       = ~r_tail;
    assign mem_byp_valid = mem_to_wb_valid && r_regw[w_young];
    assign mem_byp_addr  = mem_byp_valid ? r_addr[w_young] : '0;
    assign mem_byp_data  = mem_byp_valid ? r_data[w_young] : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: decode vector table,
//             back-pressure / reset / bypass sequences and a randomized run
//             against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int c_AW   = 5;
    localparam int c_DW   = 32;
    localparam int c_IN_W = c_DW*2 + c_AW + 4;
    localparam int c_OW   = c_DW + c_AW + 1;

    logic              clk;
    logic              rst;
    logic              exe_to_mem_valid;
    logic              mem_to_exe_ready;
    logic [c_IN_W-1:0] exe_to_mem_bus;
    logic              mem_to_wb_valid;
    logic              wb_to_mem_ready;
    logic [c_OW-1:0]   mem_to_wb_bus;
`ifdef MEM_STAGE_BYPASS_EN
    logic              mem_byp_valid;
    logic [c_AW-1:0]   mem_byp_addr;
    logic [c_DW-1:0]   mem_byp_data;
`endif

    mem_stage #(.REG_ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) u_dut (
        .clk              (clk),
        .rst              (rst),
        .exe_to_mem_valid (exe_to_mem_valid),
        .mem_to_exe_ready (mem_to_exe_ready),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .wb_to_mem_ready  (wb_to_mem_ready),
        .mem_to_wb_bus    (mem_to_wb_bus)
`ifdef MEM_STAGE_BYPASS_EN
        ,
        .mem_byp_valid    (mem_byp_valid),
        .mem_byp_addr     (mem_byp_addr),
        .mem_byp_data     (mem_byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference resolution written from the decode rules with arithmetic.
    function automatic logic [c_OW-1:0] model(input logic [c_IN_W-1:0] b);
        logic            regw;
        logic [c_AW-1:0] addr;
        logic [31:0]     alu, ld, d;
        logic [2:0]      li;
        regw = b[72];
        addr = b[71:67];
        alu  = b[66:35];
        li   = b[34:32];
        ld   = b[31:0];
        case (li)
            3'd0: d = alu;
            3'd1: begin d = ld % 256;   if (d >= 128)   d = d - 32'd256;   end
            3'd2: begin d = ld % 65536; if (d >= 32768) d = d - 32'd65536; end
            3'd3: d = ld;
            3'd4: d = ld % 256;
            3'd5: d = ld % 65536;
            default: begin d = 0; regw = 1'b0; end
        endcase
        if (addr == 0) regw = 1'b0;
        return {regw, addr, d};
    endfunction

    function automatic logic [c_IN_W-1:0] mk(input logic regw, input logic [4:0] addr,
                                             input logic [31:0] alu, input logic [2:0] li,
                                             input logic [31:0] ld);
        return {regw, addr, alu, li, ld};
    endfunction

    typedef struct {
        logic [c_IN_W-1:0] bus;
        logic [c_OW-1:0]   exp;
    } vec_t;

    vec_t tbl[13];
    logic [c_OW-1:0] q[$];

    initial begin
        // Hand-computed decode vectors.
        tbl[0]  = '{mk(1,3,32'h8000_0010,1,32'h0000_0080),  {1'b1,5'd3,32'hFFFF_FF80}};
        tbl[1]  = '{mk(1,5,32'h0,4,32'h1234_5680),          {1'b1,5'd5,32'h0000_0080}};
        tbl[2]  = '{mk(1,5,32'h0,5,32'h1234_5680),          {1'b1,5'd5,32'h0000_5680}};
        tbl[3]  = '{mk(1,5,32'h0,2,32'h0000_8001),          {1'b1,5'd5,32'hFFFF_8001}};
        tbl[4]  = '{mk(1,9,32'h1,3,32'hDEAD_BEEF),          {1'b1,5'd9,32'hDEAD_BEEF}};
        tbl[5]  = '{mk(1,31,32'h1234_5678,0,32'hFFFF_FFFF), {1'b1,5'd31,32'h1234_5678}};
        tbl[6]  = '{mk(1,0,32'h5,0,32'h0),                  {1'b0,5'd0,32'h0000_0005}};
        tbl[7]  = '{mk(1,4,32'h77,7,32'h1234_5678),         {1'b0,5'd4,32'h0}};
        tbl[8]  = '{mk(1,6,32'h77,6,32'h1234_5678),         {1'b0,5'd6,32'h0}};
        tbl[9]  = '{mk(1,2,32'h0,1,32'hFFFF_FF7F),          {1'b1,5'd2,32'h0000_007F}};
        tbl[10] = '{mk(0,8,32'hAA,0,32'h0),                 {1'b0,5'd8,32'h0000_00AA}};
        tbl[11] = '{mk(1,1,32'h0,2,32'h1234_7FFF),          {1'b1,5'd1,32'h0000_7FFF}};
        tbl[12] = '{mk(1,3,32'h0,4,32'hFFFF_FFFF),          {1'b1,5'd3,32'h0000_00FF}};

        rst = 1'b0;
        exe_to_mem_valid = 1'b0;
        exe_to_mem_bus = '0;
        wb_to_mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", mem_to_wb_valid, 0);
        check("reset_ready", mem_to_exe_ready, 1);
        check("reset_bus", mem_to_wb_bus, 0);
        rst = 1'b1;

        // ---- decode table: one entry at a time, 1-cycle latency ----
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            exe_to_mem_valid = 1'b1;
            exe_to_mem_bus   = tbl[i].bus;
            @(negedge clk);
            exe_to_mem_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), mem_to_wb_valid, 1);
            check($sformatf("vec%0d_bus", i), mem_to_wb_bus, tbl[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_empty_bus", i), mem_to_wb_bus, 0);
        end

        // ---- back-pressure: A, B accepted, C held, in-order drain ----
        wb_to_mem_ready = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk(1,10,32'hA,0,0);
        @(negedge clk);
        check("bp_ready_cnt1", mem_to_exe_ready, 1);
        exe_to_mem_bus = mk(1,11,32'hB,0,0);
        @(negedge clk);
        check("bp_ready_cnt2", mem_to_exe_ready, 0);
        exe_to_mem_bus = mk(1,12,32'hC,0,0);
        @(negedge clk);
        check("bp_still_full", mem_to_exe_ready, 0);
        check("bp_head_A", mem_to_wb_bus, {1'b1,5'd10,32'hA});
        wb_to_mem_ready = 1'b1;
        @(negedge clk);
        check("bp_head_B", mem_to_wb_bus, {1'b1,5'd11,32'hB});
        check("bp_ready_after_A", mem_to_exe_ready, 1);
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        check("bp_head_C", mem_to_wb_bus, {1'b1,5'd12,32'hC});
        @(negedge clk);
        check("bp_drained", mem_to_wb_valid, 0);

        // ---- reset while full ----
        wb_to_mem_ready = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk(1,13,32'h13,0,0);
        @(negedge clk);
        exe_to_mem_bus = mk(1,14,32'h14,0,0);
        @(negedge clk);
        check("rstfull_full", mem_to_exe_ready, 0);
        exe_to_mem_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstfull_valid", mem_to_wb_valid, 0);
        check("rstfull_ready", mem_to_exe_ready, 1);
        check("rstfull_bus", mem_to_wb_bus, 0);
        wb_to_mem_ready = 1'b1;
        @(negedge clk);
        check("rstfull_no_stale", mem_to_wb_valid, 0);

`ifdef MEM_STAGE_BYPASS_EN
        // ---- bypass shows the youngest entry ----
        wb_to_mem_ready = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus = mk(1,7,32'h42,0,32'hDEAD_0000);
        @(negedge clk);
        check("byp1_valid", mem_byp_valid, 1);
        check("byp1_addr", mem_byp_addr, 7);
        check("byp1_data", mem_byp_data, 32'h42);
        exe_to_mem_bus = mk(1,9,32'h99,0,32'hBEEF_0000);
        @(negedge clk);
        exe_to_mem_valid = 1'b0;
        check("byp2_addr", mem_byp_addr, 9);
        check("byp2_data", mem_byp_data, 32'h99);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("byp_after_reset", mem_byp_valid, 0);
`endif

        // ---- randomized run against the queue model ----
        exe_to_mem_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < 3000; i++) begin
            logic deq, enq;
            logic [c_OW-1:0] head;
            head = (q.size() != 0) ? q[0] : '0;
            check("rnd_valid", mem_to_wb_valid, q.size() != 0);
            check("rnd_ready", mem_to_exe_ready, q.size() != 2);
            check("rnd_bus", mem_to_wb_bus, head);
`ifdef MEM_STAGE_BYPASS_EN
            begin
                logic [c_OW-1:0] yng;
                logic bv;
                yng = (q.size() != 0) ? q[q.size()-1] : '0;
                bv = yng[c_OW-1];
                check("rnd_byp_valid", mem_byp_valid, bv);
                check("rnd_byp_addr", mem_byp_addr, bv ? yng[36:32] : 5'd0);
                check("rnd_byp_data", mem_byp_data, bv ? yng[31:0] : 32'd0);
            end
`endif
            rst = ($urandom_range(0, 63) != 0);
            exe_to_mem_valid = $urandom_range(0, 1);
            wb_to_mem_ready = $urandom_range(0, 1);
            exe_to_mem_bus = mk($urandom_range(0, 1),
                                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                                $urandom, 3'($urandom), $urandom);
            if (!rst) begin
                q.delete();
            end else begin
                deq = (q.size() != 0) && wb_to_mem_ready;
                enq = exe_to_mem_valid && (q.size() != 2);
                if (deq) void'(q.pop_front());
                if (enq) q.push_back(model(exe_to_mem_bus));
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
